// File: rtl/weighted_divider.sv
// weighted_divider: recovers operand a from a weighted product P
// by restoring division, P / (2^(k1-k3) + 2^(k2-k3)).
module weighted_divider #(
  parameter int PW = 16,
  parameter int KW = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PW-1:0]       p,
  input  logic [KW-1:0]       k1,
  input  logic [KW-1:0]       k2,
  input  logic [KW-1:0]       k3,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [PW-1:0]       q,
  output logic [(1<<KW):0]    rem,
  output logic                exact
);

  localparam int DW = (1 << KW) + 1;
  localparam int CW = $clog2(PW);
  localparam int AW = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;

  logic [PW-1:0]   r_dvd;
  logic [PW-1:0]   r_quo;
  logic [DW-1:0]   r_d;
  logic [DW-1:0]   r_prem;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_q;
  logic [DW-1:0]   r_rem;
  logic            r_err;
  logic            r_exact;

  logic [KW-1:0]   w_s1;
  logic [KW-1:0]   w_s2;
  logic [DW-1:0]   w_d;
  logic            w_bad;
  logic [DW:0]     w_trial;
  logic            w_ge;
  logic [DW:0]     w_nrem;
  logic [PW-1:0]   w_nquo;
  logic            w_last;
  logic            w_acc;

  assign w_s1    = k1 - k3;
  assign w_s2    = k2 - k3;
  assign w_d     = (DW'(1) << w_s1) + (DW'(1) << w_s2);
  assign w_bad   = (k1 < k3) || (k2 < k3);
  assign w_acc   = (r_state == S_IDLE) && start;

  assign w_trial = {r_prem, r_dvd[PW-1]};
  assign w_ge    = w_trial >= {1'b0, r_d};
  assign w_nrem  = w_ge ? (w_trial - {1'b0, r_d}) : w_trial;
  assign w_nquo  = {r_quo[PW-2:0], w_ge};
  assign w_last  = (r_state == S_DIV) &&
                   (r_cnt == CW'(PW - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // next-state decode
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt = w_bad ? S_DONE : S_DIV;
      end
      S_DIV: begin
        if (w_last) w_nxt = S_DONE;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // datapath: latch request, iterate, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd   <= '0;
      r_quo   <= '0;
      r_d     <= '0;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
      r_exact <= 1'b0;
    end else if (w_acc) begin
      r_dvd   <= p;
      r_quo   <= '0;
      r_d     <= w_d;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_err   <= w_bad;
      r_exact <= 1'b0;
    end else if (r_state == S_DIV) begin
      r_dvd  <= {r_dvd[PW-2:0], 1'b0};
      r_quo  <= w_nquo;
      r_prem <= w_nrem[DW-1:0];
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_q     <= w_nquo;
        r_rem   <= w_nrem[DW-1:0];
        r_exact <= (w_nrem == '0) &&
                   (w_nquo[PW-1:AW] == '0);
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign err   = r_err;
  assign q     = r_q;
  assign rem   = r_rem;
  assign exact = r_exact;

endmodule

// File: tb/tb_weighted_divider.sv
// tb_weighted_divider: random and directed requests against
// a plain-arithmetic model of the weighted division.
module tb_weighted_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] p;
  logic [2:0]  k1, k2, k3;
  logic        busy, done, err, exact;
  logic [15:0] q;
  logic [8:0]  rem;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  weighted_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .p(p), .k1(k1), .k2(k2), .k3(k3),
    .busy(busy), .done(done), .err(err),
    .q(q), .rem(rem), .exact(exact)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one request; optionally poke start mid-division
  task automatic run_req(input logic [15:0] pp,
                         input logic [2:0] a,
                         input logic [2:0] b,
                         input logic [2:0] c,
                         input bit poke);
    int e_err, e_q, e_rem, e_ex, e_d, e_lat, cyc;
    e_err = (a < c) || (b < c);
    if (e_err) begin
      e_q = 0; e_rem = 0; e_ex = 0; e_lat = 0;
    end else begin
      e_d   = (1 << (a - c)) + (1 << (b - c));
      e_q   = pp / e_d;
      e_rem = pp % e_d;
      e_ex  = (e_rem == 0) && (e_q < 256);
      e_lat = 16;
    end
    p = pp; k1 = a; k2 = b; k3 = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_acc", busy, 1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (poke && (cyc == 3 || cyc == 8)) begin
        start = 1'b1;
        p = 16'($urandom);
        k1 = 3'($urandom); k2 = 3'($urandom); k3 = 0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, e_lat);
    chk("q", q, e_q);
    chk("rem", rem, e_rem);
    chk("exact", exact, e_ex);
    chk("err", err, e_err);
    chk("busy_done", busy, 1);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("q_hold", q, e_q);
    chk("rem_hold", rem, e_rem);
    chk("err_hold", err, e_err);
  endtask

  initial begin
    int dcount;
    logic [2:0] a, b, c;
    rst = 1'b1; start = 1'b0; p = '0;
    k1 = '0; k2 = '0; k3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
    chk("rst_rem", rem, 0);
    chk("rst_err", err, 0);
    chk("rst_exact", exact, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(16'd10, 3'd3, 3'd3, 3'd3, 0);
    chk("basic_q", q, 5);
    run_req(16'd2560, 3'd7, 3'd0, 3'd0, 0);
    chk("mixed_q", q, 19);
    chk("mixed_rem", rem, 109);
    run_req(16'hFFFF, 3'd0, 3'd0, 3'd0, 0);
    chk("max_q", q, 16'h7FFF);
    run_req(16'd1234, 3'd2, 3'd5, 3'd3, 0);
    run_req(16'd300, 3'd4, 3'd1, 3'd0, 0);
    chk("err_clear", err, 0);
    run_req(16'd4000, 3'd6, 3'd2, 3'd1, 1);

    // reset in the middle of a division
    p = 16'd999; k1 = 3; k2 = 1; k3 = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_q", q, 0);
    chk("mid_rem", rem, 0);
    chk("mid_err", err, 0);
    chk("mid_exact", exact, 0);
    rst = 1'b0;
    dcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("mid_nodone", dcount, 0);
    run_req(16'd10, 3'd3, 3'd3, 3'd3, 0);
    chk("post_rst_q", q, 5);

    // start held high: back-to-back with one idle cycle
    p = 16'd100; k1 = 1; k2 = 1; k3 = 1; start = 1'b1;
    dcount = 0;
    while (!done && dcount < 100) begin
      @(posedge clk); #1;
      dcount++;
    end
    chk("b2b_q1", q, 50);
    p = 16'd90;
    @(posedge clk); #1;
    chk("b2b_idle", busy, 0);
    @(posedge clk); #1;
    chk("b2b_acc", busy, 1);
    start = 1'b0;
    dcount = 0;
    while (!done && dcount < 100) begin
      @(posedge clk); #1;
      dcount++;
    end
    chk("b2b_lat", dcount, 16);
    chk("b2b_q2", q, 45);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom); b = 3'($urandom);
      c = 3'($urandom_range(0, (i % 4 == 0) ? 7 : 2));
      run_req(16'($urandom), a, b, c, (i % 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/weighted_divider.md
Name: weighted_divider

Overview:
- Inverse of the weighted adder/multiplier: takes a 16-bit product P = {overflow,y} and the shift codes k1, k2, k3, and recovers the operand a.
- Computes a = P / (2^(k1-k3) + 2^(k2-k3)) with an iterative restoring divider, one quotient bit per clock.
- Sits on the receive side of the weighted-arithmetic datapath. Used to check or undo a weighted product.

Parameters:
- PW, 16, product/quotient width in bits (one DIV iteration per bit).
- KW, 3, shift-code width; divisor width DW = 2^KW + 1 (9 at default).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- p  input  PW  product to decompose ({overflow,y})
- k1  input  KW  shift code 1
- k2  input  KW  shift code 2
- k3  input  KW  reference shift code
- busy  output  1  high from the accepting edge through the DONE cycle
- done  output  1  one-cycle pulse; results valid
- err  output  1  k1<k3 or k2<k3 on the accepted request
- q  output  PW  quotient (recovered a)
- rem  output  DW  remainder
- exact  output  1  rem==0 and q[PW-1:8]==0 (P is a legal weighted product of an 8-bit a)

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - busy, done, err, exact = 0; q = 0; rem = 0.
  - Reset wins over every other event, including mid-DIV. An aborted operation produces no done.
- States: IDLE, DIV, DONE.
- IDLE, start=1 at edge E0:
  - Latch p into the dividend shift register.
  - Divisor d = (1<<(k1-k3)) + (1<<(k2-k3)), computed at full DW width. No truncation; max d = 256.
  - Clear the partial remainder and set busy=1.
  - If k1<k3 or k2<k3: err=1, q=0, rem=0, exact=0, next state DONE.
  - Otherwise: err=0, iteration counter=0, next state DIV.
- DIV, one iteration per edge (edges E1..E_PW):
  - Shift the partial remainder left, bringing in the dividend MSB.
  - If remainder >= d: subtract d and shift in quotient bit 1; else shift in 0.
  - Partial remainder is held at DW+1 bits so the compare never overflows.
  - At E_PW (counter == PW-1), write final q and rem, compute exact, next state DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE at the next edge (busy falls).
- Latency:
  - Valid request: done high in the cycle after edge E_PW, i.e. PW cycles after acceptance (16 at default).
  - Error request: done high in the cycle after E0.
- Output holding: q, rem, err and exact hold their values after DONE until the next accepted start overwrites them at its E0.
- start while busy (DIV or DONE): ignored. No queuing, and p/k changes have no effect.
- start held high continuously: a new request is accepted on the first IDLE edge after DONE, giving back-to-back operations with one idle cycle between them.
- k1==k3 and k2==k3: d=2 (minimum divisor). The quotient can reach 2^(PW-1)-1, so q is full PW width.
- No divide-by-zero exists, since d>=2.

Test Plan:
- Basic case: p=10, k1=k2=k3=3 -> d=2; after 16 cycles q=5, rem=0, exact=1, err=0; done high for one cycle.
- Mixed weights: p=2560, k1=7, k2=0, k3=0 -> d=129; q=19, rem=109, exact=0.
- Maximum dividend: p=16'hFFFF, k1=k2=k3=0 -> q=16'h7FFF, rem=1, exact=0.
- Error request: k1=2, k2=5, k3=3, start -> err=1, q=0, rem=0, done in the cycle after acceptance; next valid request clears err.
- start pulsed at cycles 3 and 8 of a running DIV with different p -> ignored; result matches the first request and exactly one done is seen.
- rst asserted at DIV cycle 7 -> next cycle all outputs 0, state IDLE, no done; a new request afterwards completes normally (p=10, k=3,3,3 -> q=5).
